fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb.sv | 145 ++++++++++++++
 tb/tb_fifo_wr_arb.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin burst arbiter that funnels NREQ word streams into one FIFO write port.
// Define FIFO_WR_ARB_STAT_EN to build the per-requester saturating transfer counters on O_XFER_CNT.
module fifo_wr_arb #(
  parameter int DW        = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic              I_CLK,
  input  logic              I_RST,
  input  logic [NREQ-1:0]   I_REQ,
  input  logic [NREQ*DW-1:0] I_DATA,
  output logic [NREQ-1:0]   O_ACK,
  output logic [NREQ-1:0]   O_GNT,
  output logic              O_WR_REQ,
  output logic [DW-1:0]     O_WR_DATA,
  input  logic              I_WR_FULL,
  output logic [NREQ*16-1:0] O_XFER_CNT
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BEAT_LAST = CW'(MAX_BURST - 1);
  localparam logic [PW-1:0] IDX_LAST  = PW'(NREQ - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t          state_r, state_nxt_s;
  logic [NREQ-1:0] gnt_r, gnt_nxt_s;
  logic [PW-1:0]   gidx_r, gidx_nxt_s;
  logic [PW-1:0]   ptr_r, ptr_nxt_s;
  logic [CW-1:0]   bcnt_r, bcnt_nxt_s;
  logic [PW-1:0]   cand_s, pick_s;
  logic            found_s;
  logic [NREQ-1:0] ack_s;
  logic            req_g_s;

  // Round-robin search: first requesting index at or after the pointer.
  always_comb begin
    found_s = 1'b0;
    pick_s  = {PW{1'b0}};
    cand_s  = {PW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      cand_s = PW'((int'(ptr_r) + k) % NREQ);
      if (!found_s && I_REQ[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Accept strobe for the granted requester; a full FIFO blocks every transfer.
  always_comb begin
    ack_s   = {NREQ{1'b0}};
    req_g_s = I_REQ[gidx_r];
    if (state_r == BURST) begin
      ack_s[gidx_r] = req_g_s & ~I_WR_FULL;
    end else begin
      ack_s = {NREQ{1'b0}};
    end
  end

  // Next-state logic: a burst ends when the requester drops or the last allowed word goes through.
  always_comb begin
    state_nxt_s = state_r;
    gnt_nxt_s   = gnt_r;
    gidx_nxt_s  = gidx_r;
    ptr_nxt_s   = ptr_r;
    bcnt_nxt_s  = bcnt_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_nxt_s = BURST;
          gidx_nxt_s  = pick_s;
          gnt_nxt_s   = {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
          bcnt_nxt_s  = {CW{1'b0}};
        end else begin
          gnt_nxt_s   = {NREQ{1'b0}};
        end
      end
      BURST: begin
        if (!req_g_s || ((|ack_s) && (bcnt_r == BEAT_LAST))) begin
          state_nxt_s = IDLE;
          gnt_nxt_s   = {NREQ{1'b0}};
          bcnt_nxt_s  = {CW{1'b0}};
          ptr_nxt_s   = (gidx_r == IDX_LAST) ? {PW{1'b0}} : gidx_r + 1'b1;
        end else if (|ack_s) begin
          bcnt_nxt_s  = bcnt_r + 1'b1;
        end else begin
          bcnt_nxt_s  = bcnt_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        gnt_nxt_s   = {NREQ{1'b0}};
        bcnt_nxt_s  = {CW{1'b0}};
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state_r <= IDLE;
      gnt_r   <= {NREQ{1'b0}};
      gidx_r  <= {PW{1'b0}};
      ptr_r   <= {PW{1'b0}};
      bcnt_r  <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      gnt_r   <= gnt_nxt_s;
      gidx_r  <= gidx_nxt_s;
      ptr_r   <= ptr_nxt_s;
      bcnt_r  <= bcnt_nxt_s;
    end
  end

  assign O_ACK     = ack_s;
  assign O_GNT     = gnt_r;
  assign O_WR_REQ  = |ack_s;
  assign O_WR_DATA = I_DATA[gidx_r*DW +: DW];

`ifdef FIFO_WR_ARB_STAT_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    logic [15:0] cnt_r;

    // Saturating count of words accepted from requester i.
    always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
        cnt_r <= 16'h0000;
      end else if (ack_s[i] && (cnt_r != 16'hFFFF)) begin
        cnt_r <= cnt_r + 16'h0001;
      end else begin
        cnt_r <= cnt_r;
      end
    end

    assign O_XFER_CNT[i*16 +: 16] = cnt_r;
  end
`else
  assign O_XFER_CNT = {(NREQ*16){1'b0}};
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: requester queues drive the DUT, a scoreboard holds expected FIFO words
// and grant order; covers reset, single-requester bursting, fairness, backpressure, mid-burst reset and stats.
`timescale 1ns/1ps
module tb_fifo_wr_arb;
  localparam int DW    = 8;
  localparam int NREQ  = 4;
  localparam int MB    = 4;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic [3:0]  gnt;
  logic        wr_req;
  logic [7:0]  wr_data;
  logic        wr_full;
  logic [63:0] xfer;

  fifo_wr_arb #(.DW(DW), .NREQ(NREQ), .MAX_BURST(MB)) dut (
    .I_CLK(clk), .I_RST(rst), .I_REQ(req), .I_DATA(data), .O_ACK(ack), .O_GNT(gnt),
    .O_WR_REQ(wr_req), .O_WR_DATA(wr_data), .I_WR_FULL(wr_full), .O_XFER_CNT(xfer)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] rmem [NREQ][DEPTH];
  int rrd [NREQ];
  int rwr [NREQ];
  logic [7:0] sb_q [$];
  logic [3:0] gnt_q [$];
  int wr_cyc_q [$];
  logic [3:0] prev_gnt;
  logic [3:0] bp_gnt;
  int idle_run, full_left, n_wr;
  bit chk_gap, bp_arm, refill0;
  logic [15:0] exp_stat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input int r, input logic [7:0] w);
    rmem[r][rwr[r] % DEPTH] = w;
    rwr[r]++;
    sb_q.push_back(w);
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (rrd[i] != rwr[i]);
      data[i*DW +: DW] = rmem[i][rrd[i] % DEPTH];
    end
    wr_full = (full_left > 0);
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < NREQ; i++) p = p | (rrd[i] != rwr[i]);
    return p;
  endfunction

  // One clock: sample/check at negedge, then retire accepted words and update inputs after posedge.
  task automatic step();
    logic [3:0] acc = 4'h0;
    @(negedge clk);
    cyc++;
    if (rst) begin
      check("rst_gnt", gnt, 0);
      check("rst_ack", ack, 0);
      check("rst_wr_req", wr_req, 0);
      idle_run = 0;
    end else begin
      if (wr_full) begin
        check("full_wr_req", wr_req, 0);
        check("full_ack", ack, 0);
        if (bp_gnt != 4'h0) check("bp_gnt_held", gnt, bp_gnt);
      end
      if (ack != 4'h0) check("ack_outside_gnt", ack & ~gnt, 0);
      if (gnt != 4'h0 && gnt != prev_gnt) begin
        if (gnt_q.size() == 0) check("gnt_unexpected", gnt, 0);
        else check("gnt_seq", gnt, gnt_q.pop_front());
        if (chk_gap) check("idle_gap", idle_run, 1);
      end
      idle_run = (gnt == 4'h0) ? idle_run + 1 : 0;
      if (refill0 && gnt == 4'b0010) begin
        load(0, 8'hA4);
        refill0 = 1'b0;
      end
      if (wr_req) begin
        if (sb_q.size() == 0) check("wr_unexpected", 64'(wr_req), 0);
        else check("wr_data", wr_data, sb_q.pop_front());
        wr_cyc_q.push_back(cyc);
        n_wr++;
      end
      acc = ack;
    end
    prev_gnt = gnt;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (acc[i]) rrd[i]++;
    if (full_left > 0) full_left--;
    if (bp_arm && n_wr == 2) begin
      full_left = 3;
      bp_arm = 1'b0;
    end
    drive();
  endtask

  task automatic run(input string tag, input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || pending()) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drained"}, sb_q.size(), 0);
    check({tag, "_grants_left"}, gnt_q.size(), 0);
  endtask

  task automatic settle();
    repeat (3) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    req = 4'h0; data = 32'h0; wr_full = 1'b0; rst = 1'b1;
    full_left = 0; bp_arm = 1'b0; bp_gnt = 4'h0; chk_gap = 1'b0; refill0 = 1'b0;
    prev_gnt = 4'h0; idle_run = 0; n_wr = 0;
    for (int i = 0; i < NREQ; i++) begin rrd[i] = 0; rwr[i] = 0; end

    // Reset held with every requester active, then fairness from pointer 0
    for (int i = 0; i < NREQ; i++) load(i, 8'(8'hA0 + i));
    drive();
    repeat (3) step();
    gnt_q.push_back(4'b0001); gnt_q.push_back(4'b0010); gnt_q.push_back(4'b0100);
    gnt_q.push_back(4'b1000); gnt_q.push_back(4'b0001);
    refill0 = 1'b1;
    chk_gap = 1'b1;
    rst = 1'b0;
    run("fair", 60);

    // Single requester, six words: burst of MAX_BURST, one idle cycle, then the rest
    settle();
    idle_run = 0; n_wr = 0; wr_cyc_q.delete();
    for (int j = 0; j < 6; j++) load(1, 8'(8'h11 + j));
    gnt_q.push_back(4'b0010); gnt_q.push_back(4'b0010);
    drive();
    run("single", 40);
    check("single_count", wr_cyc_q.size(), 6);
    if (wr_cyc_q.size() == 6)
      for (int j = 1; j < 6; j++) check("single_spacing", wr_cyc_q[j] - wr_cyc_q[j-1], (j == 4) ? 2 : 1);
    chk_gap = 1'b0;

    // Backpressure: FIFO full for three cycles after the second word
    settle();
    n_wr = 0; wr_cyc_q.delete(); bp_arm = 1'b1; bp_gnt = 4'b0100;
    for (int j = 0; j < 4; j++) load(2, 8'(8'h21 + j));
    gnt_q.push_back(4'b0100);
    drive();
    run("bp", 40);
    check("bp_release", gnt, 0);
    check("bp_count", wr_cyc_q.size(), 4);
    if (wr_cyc_q.size() == 4) begin
      check("bp_stall_gap", wr_cyc_q[2] - wr_cyc_q[1], 4);
      check("bp_resume_gap", wr_cyc_q[3] - wr_cyc_q[2], 1);
    end
    bp_gnt = 4'h0;

    // Reset in the middle of a burst from requester 3
    settle();
    n_wr = 0;
    for (int j = 0; j < 6; j++) load(3, 8'(8'h31 + j));
    gnt_q.push_back(4'b1000);
    drive();
    n = 0;
    while (n_wr < 2 && n < 20) begin step(); n++; end
    check("mr_two_words", n_wr, 2);
    load(0, 8'h01);
    drive();
    #2;
    rst = 1'b1;
    #1;
    check("mr_gnt", gnt, 0);
    check("mr_ack", ack, 0);
    check("mr_wr_req", wr_req, 0);
    sb_q.delete();
    sb_q.push_back(8'h01);
    for (int j = rrd[3]; j < rwr[3]; j++) sb_q.push_back(rmem[3][j % DEPTH]);
    gnt_q.delete();
    gnt_q.push_back(4'b0001); gnt_q.push_back(4'b1000);
    step();
    rst = 1'b0;
    run("midrst", 60);

    // Statistics: ten words from requester 2 after a fresh reset
    settle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int j = 0; j < 10; j++) load(2, 8'(8'h40 + j));
    gnt_q.push_back(4'b0100); gnt_q.push_back(4'b0100); gnt_q.push_back(4'b0100);
    drive();
    run("stat", 80);
    settle();
`ifdef FIFO_WR_ARB_STAT_EN
    exp_stat = 16'd10;
`else
    exp_stat = 16'd0;
`endif
    for (int i = 0; i < NREQ; i++) check("xfer_cnt", xfer[i*16 +: 16], (i == 2) ? exp_stat : 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
